// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/physics handshake, scoring, win detection.
// All outputs registered; physics step has a watchdog and frame-overrun reporting.
module pong_game_ctrl #(
  parameter logic [7:0] WIN_SCORE    = 8'd11,
  parameter int         SERVE_FRAMES = 60,
  parameter int         HOLD_FRAMES  = 30,
  parameter int         PHYS_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       phys_done,
  input  logic [1:0] player_did_score,
  output logic       phys_update,
  output logic       paddle_update,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic       phys_timeout_err,
  output logic       frame_overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PHYS_WAIT = 3'd3,
    SCORED    = 3'd4,
    PAUSED    = 3'd5,
    GAME_OVER = 3'd6
  } state_t;

  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [15:0] WD_LAST    = 16'(PHYS_TIMEOUT - 1);

  state_t      cur, nxt;
  logic        start_q, start_lock, start_evt;
  logic [7:0]  fcnt, fcnt_n;
  logic [15:0] wdog, wdog_n;
  logic [7:0]  sl_n, sr_n;
  logic [1:0]  win_n;
  logic        dir_n, phys_n, pad_n, br_n, to_n, ov_n;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // start_lock masks a start level that was already high while in reset
  assign start_evt = start & ~start_q & ~start_lock;
  assign state     = cur;

  always_comb begin
    nxt    = cur;
    fcnt_n = fcnt;
    wdog_n = wdog;
    sl_n   = score_left;
    sr_n   = score_right;
    win_n  = winner;
    dir_n  = serve_dir;
    phys_n = 1'b0;
    pad_n  = 1'b0;
    br_n   = 1'b0;
    to_n   = 1'b0;
    ov_n   = 1'b0;
    case (cur)
      IDLE, GAME_OVER: begin
        if (start_evt) begin
          nxt    = SERVE;
          sl_n   = 8'd0;
          sr_n   = 8'd0;
          win_n  = 2'b00;
          fcnt_n = 8'd0;
          br_n   = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (fcnt == SERVE_LAST) nxt = PLAY;
          else fcnt_n = fcnt + 8'd1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (pause) begin
            nxt = PAUSED;
          end else begin
            nxt    = PHYS_WAIT;
            phys_n = 1'b1;
            pad_n  = 1'b1;
            wdog_n = 16'd0;
          end
        end
      end
      PAUSED: begin
        if (frame_tick && !pause) nxt = PLAY;
      end
      PHYS_WAIT: begin
        ov_n   = frame_tick & ~phys_done;
        wdog_n = wdog + 16'd1;
        if (phys_done) begin
          case (player_did_score)
            2'b10: begin
              nxt    = SCORED;
              sl_n   = sat_inc(score_left);
              dir_n  = 1'b1;
              fcnt_n = 8'd0;
            end
            2'b01: begin
              nxt    = SCORED;
              sr_n   = sat_inc(score_right);
              dir_n  = 1'b0;
              fcnt_n = 8'd0;
            end
            default: nxt = PLAY;
          endcase
        end else if (wdog == WD_LAST) begin
          nxt  = PLAY;
          to_n = 1'b1;
        end
      end
      SCORED: begin
        if (frame_tick) begin
          if (fcnt == HOLD_LAST) begin
            if (score_left >= WIN_SCORE || score_right >= WIN_SCORE) begin
              nxt   = GAME_OVER;
              win_n = (score_left >= WIN_SCORE) ? 2'b01 : 2'b10;
            end else begin
              nxt    = SERVE;
              fcnt_n = 8'd0;
              br_n   = 1'b1;
            end
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur              <= IDLE;
      start_q          <= 1'b0;
      start_lock       <= start;
      fcnt             <= 8'd0;
      wdog             <= 16'd0;
      score_left       <= 8'd0;
      score_right      <= 8'd0;
      winner           <= 2'b00;
      serve_dir        <= 1'b0;
      phys_update      <= 1'b0;
      paddle_update    <= 1'b0;
      ball_reset       <= 1'b0;
      phys_timeout_err <= 1'b0;
      frame_overrun    <= 1'b0;
    end else begin
      cur              <= nxt;
      start_q          <= start;
      if (!start) start_lock <= 1'b0;
      fcnt             <= fcnt_n;
      wdog             <= wdog_n;
      score_left       <= sl_n;
      score_right      <= sr_n;
      winner           <= win_n;
      serve_dir        <= dir_n;
      phys_update      <= phys_n;
      paddle_update    <= pad_n;
      ball_reset       <= br_n;
      phys_timeout_err <= to_n;
      frame_overrun    <= ov_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: per-cycle vector table plus scripted game sequences.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_PWAIT = 3'd3,
                         S_SCORED = 3'd4, S_PAUSED = 3'd5, S_OVER = 3'd6;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start, pause, phys_done;
  logic [1:0] player_did_score;
  logic       phys_update, paddle_update, ball_reset, serve_dir;
  logic [7:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state;
  logic       phys_timeout_err, frame_overrun;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .phys_done(phys_done), .player_did_score(player_did_score),
    .phys_update(phys_update), .paddle_update(paddle_update), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score_left(score_left), .score_right(score_right),
    .winner(winner), .state(state), .phys_timeout_err(phys_timeout_err),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ft, pause, pd;
    logic [1:0] pds;
    logic [2:0] st;
    logic       phys, pad, ovr;
    logic [7:0] sl, sr;
    logic       dir;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic ft, input logic pa, input logic pd, input logic [1:0] pds,
                              input logic [2:0] st, input logic ph, input logic pad, input logic ovr,
                              input logic [7:0] sl, input logic [7:0] sr, input logic dir);
    vec_t v;
    v = '{ft, pa, pd, pds, st, ph, pad, ovr, sl, sr, dir};
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic serve_to_play();
    int brc;
    brc = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (ball_reset) brc++;
      cyc();
      if (ball_reset) brc++;
    end
    chk("serve_59_ticks", {13'd0, state}, {13'd0, S_SERVE});
    tick();
    chk("serve_60th_tick", {13'd0, state}, {13'd0, S_PLAY});
    chk("serve_no_extra_ball_reset", brc[15:0], 16'd0);
    cyc();
  endtask

  task automatic score_point(input logic [1:0] pds, input logic [7:0] esl, input logic [7:0] esr,
                             input logic edir);
    tick();
    chk("pt_enter_wait", {13'd0, state}, {13'd0, S_PWAIT});
    chk("pt_phys_update", {15'd0, phys_update}, 16'd1);
    cyc();
    phys_done = 1'b1;
    player_did_score = pds;
    cyc();
    phys_done = 1'b0;
    player_did_score = 2'b00;
    chk("pt_scored", {13'd0, state}, {13'd0, S_SCORED});
    chk("pt_score_left", {8'd0, score_left}, {8'd0, esl});
    chk("pt_score_right", {8'd0, score_right}, {8'd0, esr});
    chk("pt_serve_dir", {15'd0, serve_dir}, {15'd0, edir});
  endtask

  task automatic hold(input logic [2:0] exp_next);
    for (int i = 0; i < 29; i++) begin
      tick();
      cyc();
    end
    chk("hold_29_ticks", {13'd0, state}, {13'd0, S_SCORED});
    tick();
    chk("hold_30th_tick", {13'd0, state}, {13'd0, exp_next});
    if (exp_next == S_SERVE) chk("hold_ball_reset", {15'd0, ball_reset}, 16'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int ovr_seen, to_seen;
    // one row per clock: inputs, then expected registered outputs after that edge
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 2'b00, S_PLAY,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 2'b10, S_PLAY,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 2'b00, S_PAUSED, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 2'b00, S_PAUSED, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 2'b00, S_PAUSED, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 2'b00, S_PLAY,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 2'b00, S_PLAY,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 2'b11, S_PLAY,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 2'b00, S_PWAIT,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 2'b10, S_SCORED, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b1);

    rst = 1'b1; start = 1'b1; frame_tick = 1'b0; pause = 1'b0;
    phys_done = 1'b0; player_did_score = 2'b00;
    cyc(); cyc();
    chk("rst_state", {13'd0, state}, {13'd0, S_IDLE});
    chk("rst_scores", {score_left, score_right}, 16'd0);
    chk("rst_winner_dir", {13'd0, winner, serve_dir}, 16'd0);
    chk("rst_pulses", {11'd0, phys_update, paddle_update, ball_reset, phys_timeout_err, frame_overrun}, 16'd0);

    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("held_start_ignored", {13'd0, state}, {13'd0, S_IDLE});
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("start_to_serve", {13'd0, state}, {13'd0, S_SERVE});
    chk("serve_ball_reset", {15'd0, ball_reset}, 16'd1);
    cyc();
    chk("ball_reset_one_cycle", {15'd0, ball_reset}, 16'd0);
    serve_to_play();

    for (int i = 0; i < 15; i++) begin
      frame_tick = tbl[i].ft; pause = tbl[i].pause;
      phys_done = tbl[i].pd; player_did_score = tbl[i].pds;
      cyc();
      chk($sformatf("vec%0d_state", i), {13'd0, state}, {13'd0, tbl[i].st});
      chk($sformatf("vec%0d_phys", i), {15'd0, phys_update}, {15'd0, tbl[i].phys});
      chk($sformatf("vec%0d_paddle", i), {15'd0, paddle_update}, {15'd0, tbl[i].pad});
      chk($sformatf("vec%0d_overrun", i), {15'd0, frame_overrun}, {15'd0, tbl[i].ovr});
      chk($sformatf("vec%0d_scores", i), {score_left, score_right}, {tbl[i].sl, tbl[i].sr});
      chk($sformatf("vec%0d_dir", i), {15'd0, serve_dir}, {15'd0, tbl[i].dir});
    end
    frame_tick = 1'b0; pause = 1'b0; phys_done = 1'b0; player_did_score = 2'b00;

    hold(S_SERVE);
    serve_to_play();
    score_point(2'b01, 8'd1, 8'd1, 1'b0);
    hold(S_SERVE);
    for (int n = 2; n <= 11; n++) begin
      serve_to_play();
      score_point(2'b10, 8'(n), 8'd1, 1'b1);
      hold((n == 11) ? S_OVER : S_SERVE);
    end
    chk("game_over_winner", {14'd0, winner}, 16'd1);
    cyc(); cyc(); cyc();
    chk("winner_held", {13'd0, state, winner}, {13'd0, S_OVER, 2'b01} >> 0);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("restart_state", {13'd0, state}, {13'd0, S_SERVE});
    chk("restart_scores", {score_left, score_right}, 16'd0);
    chk("restart_winner", {14'd0, winner}, 16'd0);
    chk("restart_dir_kept", {15'd0, serve_dir}, 16'd1);
    cyc();
    serve_to_play();

    tick();
    chk("to_enter_wait", {13'd0, state}, {13'd0, S_PWAIT});
    ovr_seen = 0; to_seen = 0;
    for (int k = 1; k <= 1023; k++) begin
      if (k == 100) frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      if (k == 100) chk("overrun_pulse", {15'd0, frame_overrun}, 16'd1);
      else if (frame_overrun) ovr_seen++;
      if (phys_timeout_err) to_seen++;
    end
    chk("overrun_single", ovr_seen[15:0], 16'd0);
    chk("to_not_early", to_seen[15:0], 16'd0);
    chk("to_still_wait", {13'd0, state}, {13'd0, S_PWAIT});
    cyc();
    chk("to_state_play", {13'd0, state}, {13'd0, S_PLAY});
    chk("to_err_pulse", {15'd0, phys_timeout_err}, 16'd1);
    chk("to_scores_kept", {score_left, score_right}, 16'd0);
    cyc();
    chk("to_err_one_cycle", {15'd0, phys_timeout_err}, 16'd0);

    tick();
    repeat (1023) cyc();
    chk("prio_still_wait", {13'd0, state}, {13'd0, S_PWAIT});
    phys_done = 1'b1; player_did_score = 2'b01;
    cyc();
    phys_done = 1'b0; player_did_score = 2'b00;
    chk("prio_scored", {13'd0, state}, {13'd0, S_SCORED});
    chk("prio_no_timeout", {15'd0, phys_timeout_err}, 16'd0);
    chk("prio_scores", {score_left, score_right}, {8'd0, 8'd1});
    chk("prio_dir", {15'd0, serve_dir}, 16'd0);

    hold(S_SERVE);
    serve_to_play();
    tick();
    chk("rstwait_enter", {13'd0, state}, {13'd0, S_PWAIT});
    rst = 1'b1; phys_done = 1'b1; player_did_score = 2'b10;
    cyc();
    phys_done = 1'b0; player_did_score = 2'b00;
    chk("rstwait_state", {13'd0, state}, {13'd0, S_IDLE});
    chk("rstwait_scores", {score_left, score_right}, 16'd0);
    chk("rstwait_dir_win", {13'd0, winner, serve_dir}, 16'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("rst_held_start_ignored", {13'd0, state}, {13'd0, S_IDLE});
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("rst_restart", {13'd0, state}, {13'd0, S_SERVE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
